gc_report_streamer: RTL and testbench

Packs the four GameCube controller poll results into the 37-byte adapter input report and streams it byte-by-byte to the USB HID endpoint. It sits between the per-port GC readers and the USB device core. A new snapshot is latched at the end of each complete 4-port poll period. A held copy is transmitted on each host frame request, so data never tears mid-report.

---
 rtl/gc_report_streamer.sv | 121 ++++++++++++
 tb/tb_gc_report_streamer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_report_streamer.sv
// gc_report_streamer: packs four GameCube poll results into the 37-byte adapter
// input report and streams it byte-by-byte to the USB HID endpoint.
// A shadow image is refreshed on every completed 4-port poll period. A separate
// active image is frozen for the duration of each report, so a report never tears.
// Optional build macro: GC_REPORT_NEUTRAL_EN (force neutral data on disconnected ports).
module gc_report_streamer #(
   parameter logic [7:0] REPORT_ID   = 8'h21,
   parameter logic [7:0] STATUS_IDLE = 8'h04,
   parameter logic [7:0] STATUS_CONN = 8'h14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   pollend,
   input  logic [3:0]   connected,
   input  logic [255:0] gc_data,
   input  logic         frame_req,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         tx_last,
   output logic         busy,
   output logic         req_drop
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;
   localparam logic [5:0] LAST_IDX = 6'd36;

   // Byte b of an image lives at element b (byte 0 = report id).
   localparam logic [36:0][7:0] DEFAULT_IMG = {{4{64'h0, STATUS_IDLE}}, REPORT_ID};

   logic [36:0][7:0] pack_img;
   logic [36:0][7:0] shadow;
   logic [36:0][7:0] active;
   logic             pe_all;
   logic             pe_q;
   logic             snap;
   logic [0:0]       state;
   logic [5:0]       idx;

   // Nine bytes of one port: element 0 = status, elements 1..8 = data bytes.
   function automatic logic [8:0][7:0] port_bytes(input logic conn, input logic [63:0] d);
      logic [15:0] bd, la, ra, ta;
      logic [7:0]  st;
      {bd, la, ra, ta} = d;
      st = conn ? STATUS_CONN : STATUS_IDLE;
      port_bytes = {ta[7:0], ta[15:8], ra[7:0], ra[15:8], la[7:0], la[15:8],
                    {4'h0, bd[6:4], bd[12]}, {bd[3:0], bd[11:8]}, st};
`ifdef GC_REPORT_NEUTRAL_EN
      // Disconnected ports report centred sticks and released triggers/buttons.
      if (!conn) begin
         port_bytes = {8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, st};
      end
`endif
   endfunction

   assign pe_all = &pollend;
   assign snap   = pe_all & ~pe_q;

   // Pack the live inputs into a complete report image.
   always_comb begin
      pack_img = {port_bytes(connected[3], gc_data[63:0]),
                  port_bytes(connected[2], gc_data[127:64]),
                  port_bytes(connected[1], gc_data[191:128]),
                  port_bytes(connected[0], gc_data[255:192]),
                  REPORT_ID};
   end

   // Registered copy of &pollend for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pe_q <= 1'b0;
      else     pe_q <= pe_all;
   end

   // Shadow image follows every snapshot event, regardless of FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       shadow <= DEFAULT_IMG;
      else if (snap) shadow <= pack_img;
   end

   // Report FSM: latch the active image on request, then walk it byte by byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= 6'd0;
         active   <= DEFAULT_IMG;
         req_drop <= 1'b0;
      end else begin
         req_drop <= frame_req && (state == ST_SEND);
         case (state)
            ST_IDLE: begin
               if (frame_req) begin
                  // Same-cycle snapshot bypasses the shadow so the report is fresh.
                  active <= snap ? pack_img : shadow;
                  idx    <= 6'd0;
                  state  <= ST_SEND;
               end
            end
            default: begin
               if (tx_ready) begin
                  if (idx == LAST_IDX) begin
                     idx   <= 6'd0;
                     state <= ST_IDLE;
                  end else begin
                     idx <= idx + 6'd1;
                  end
               end
            end
         endcase
      end
   end

   // Stream outputs derive purely from registered state, so they hold while stalled.
   always_comb begin
      tx_valid = (state == ST_SEND);
      busy     = tx_valid;
      tx_last  = tx_valid && (idx == LAST_IDX);
      tx_data  = tx_valid ? active[idx] : 8'h00;
   end

endmodule

// File: tb/tb_gc_report_streamer.sv
// Self-checking bench for gc_report_streamer: directed vector table, randomized
// snapshots against a byte-queue reference model, and multi-cycle corner cases.
module tb_gc_report_streamer;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   pollend;
   logic [3:0]   connected;
   logic [255:0] gc_data;
   logic         frame_req;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         tx_last;
   logic         busy;
   logic         req_drop;

   int n_cmp = 0;
   int n_bad = 0;
   int drop_cnt = 0;

   always #5 clk = ~clk;

   gc_report_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .pollend   (pollend),
      .connected (connected),
      .gc_data   (gc_data),
      .frame_req (frame_req),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_last   (tx_last),
      .busy      (busy),
      .req_drop  (req_drop)
   );

   always @(negedge clk) if (req_drop === 1'b1) drop_cnt++;

   task automatic check_w(input string name, input logic [295:0] act, input logic [295:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: build the report as a byte list from the packing rules, then flatten
   // with byte 0 in the most significant position.
   function automatic logic [295:0] model(input logic [3:0] conn, input logic [255:0] gc);
      logic [7:0]   q[$];
      logic [295:0] r;
      q.push_back(8'h21);
      for (int p = 0; p < 4; p++) begin
         logic [63:0] d;
         logic [15:0] bd, la, ra, ta;
         d  = 64'(gc >> (64 * (3 - p)));
         bd = d[63:48];
         la = d[47:32];
         ra = d[31:16];
         ta = d[15:0];
         q.push_back(conn[p] ? 8'h14 : 8'h04);
`ifdef GC_REPORT_NEUTRAL_EN
         if (!conn[p]) begin
            q.push_back(8'h00); q.push_back(8'h00);
            q.push_back(8'h80); q.push_back(8'h80); q.push_back(8'h80); q.push_back(8'h80);
            q.push_back(8'h00); q.push_back(8'h00);
            continue;
         end
`endif
         q.push_back(8'((((bd & 16'h000F) << 4) | ((bd >> 8) & 16'h000F))));
         q.push_back(8'((((bd >> 4) & 16'h0007) << 1) | ((bd >> 12) & 16'h0001)));
         q.push_back(8'(la >> 8)); q.push_back(8'(la & 16'h00FF));
         q.push_back(8'(ra >> 8)); q.push_back(8'(ra & 16'h00FF));
         q.push_back(8'(ta >> 8)); q.push_back(8'(ta & 16'h00FF));
      end
      r = '0;
      foreach (q[i]) r = (r << 8) | 296'(q[i]);
      return r;
   endfunction

   // Pulse &pollend high for one cycle to take a snapshot of the current inputs.
   task automatic snapshot();
      pollend = 4'hF;
      @(posedge clk); #1;
      pollend = 4'h0;
      @(posedge clk); #1;
   endtask

   // Request one report and collect it. Optionally randomize tx_ready, snapshot in the
   // request cycle, or inject a snapshot plus a frame_req when byte inject_at is shown.
   task automatic send_report(input bit rnd_ready, input bit snap_with_req, input int inject_at,
                              output logic [295:0] got);
      logic [7:0] held;
      bit         stalled;
      bit         injected;
      bit         inj_phase;
      int         n;
      got = '0; n = 0; stalled = 0; injected = 0; inj_phase = 0; held = 8'h00;
      if (snap_with_req) pollend = 4'hF;
      frame_req = 1'b1;
      @(posedge clk); #1;
      frame_req = 1'b0;
      pollend   = 4'h0;
      check_i("first_byte_latency", int'({tx_valid, busy, tx_data}), int'({2'b11, 8'h21}));
      for (int cyc = 0; cyc < 400 && n < 37; cyc++) begin
         tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (inject_at >= 0 && n == inject_at && !injected) begin
            pollend = 4'hF; frame_req = 1'b1; injected = 1; inj_phase = 1;
         end
         check_i("valid_held", int'(tx_valid), 1);
         if (stalled) check_i("data_stable_in_stall", int'(tx_data), int'(held));
         if (tx_ready) begin
            got = (got << 8) | 296'(tx_data);
            check_i("tx_last_position", int'(tx_last), (n == 36) ? 1 : 0);
            n++;
            stalled = 0;
         end else begin
            stalled = 1;
            held    = tx_data;
         end
         @(posedge clk); #1;
         if (inj_phase) begin
            pollend = 4'h0; frame_req = 1'b0; inj_phase = 0;
            check_i("req_drop_next_cycle", int'(req_drop), 1);
         end
      end
      tx_ready = 1'b1;
      check_i("handshake_count", n, 37);
      check_i("idle_after_report", int'({busy, tx_valid, tx_last}), 0);
   endtask

   typedef struct {
      logic [63:0] d;
      logic [71:0] exp;
   } vec_t;

   initial begin
      vec_t         tbl[4];
      logic [295:0] got, def_img, exp_x, exp_y;
      int           drops0;

      // Port 1 connected; expected bytes 1..9 of the report.
      tbl[0] = '{{16'h0301, 16'h8070, 16'h7F81, 16'h1020}, 72'h14_13_00_80_70_7F_81_10_20};
      tbl[1] = '{{16'hFFFF, 16'h0000, 16'hFFFF, 16'h00FF}, 72'h14_FF_0F_00_00_FF_FF_00_FF};
      tbl[2] = '{{16'h1050, 16'h1234, 16'h5678, 16'h9ABC}, 72'h14_00_0B_12_34_56_78_9A_BC};
      tbl[3] = '{{16'h0E0A, 16'hAAAA, 16'h5555, 16'h0000}, 72'h14_AE_00_AA_AA_55_55_00_00};

      def_img = 296'h21;
      for (int p = 0; p < 4; p++) def_img = (def_img << 72) | 296'({8'h04, 64'h0});

      rst = 1'b1; pollend = 4'h0; connected = 4'h0; gc_data = '0;
      frame_req = 1'b0; tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_i("reset_outputs", int'({tx_data, tx_valid, tx_last, busy, req_drop}), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Report before any snapshot carries the reset-default image.
      send_report(0, 0, -1, got);
      check_w("default_report", got, def_img);

      // Directed packing vectors.
      for (int i = 0; i < 4; i++) begin
         connected = 4'b0001;
         gc_data   = {tbl[i].d, 192'h0};
         snapshot();
         send_report(0, 0, -1, got);
         check_w("table_port1_bytes", 296'(got[287:216]), 296'(tbl[i].exp));
      end

      // Randomized snapshots with a randomly stalling consumer.
      for (int i = 0; i < 6; i++) begin
         connected = 4'($urandom);
         gc_data   = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
         snapshot();
         send_report(1, 0, -1, got);
         check_w("random_report", got, model(connected, gc_data));
      end

      // Snapshot and frame_req mid-report: report unchanged, one drop, new data next.
      connected = 4'b1010;
      gc_data   = {8{$urandom}};
      exp_x     = model(connected, gc_data);
      snapshot();
      connected = 4'b0111;
      gc_data   = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
      exp_y     = model(connected, gc_data);
      drops0    = drop_cnt;
      send_report(0, 0, 10, got);
      check_w("midreport_unchanged", got, exp_x);
      check_i("req_drop_pulses", drop_cnt - drops0, 1);
      send_report(0, 0, -1, got);
      check_w("next_report_new_data", got, exp_y);

      // Snapshot in the same cycle as frame_req: bypass delivers the new image.
      connected = 4'b1100;
      gc_data   = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
      send_report(1, 1, -1, got);
      check_w("same_cycle_bypass", got, model(connected, gc_data));

      // Port 3 disconnected with nonzero data.
      connected = 4'b1011;
      gc_data   = {192'h0, 64'h0};
      gc_data[127:64] = 64'h1234_5678_9ABC_DEF0;
      snapshot();
      send_report(0, 0, -1, got);
`ifdef GC_REPORT_NEUTRAL_EN
      check_w("port3_bytes", 296'(got[143:72]), 296'(72'h04_00_00_80_80_80_80_00_00));
`else
      check_w("port3_bytes", 296'(got[143:72]), 296'(72'h04_42_07_56_78_9A_BC_DE_F0));
`endif

      // Asynchronous reset mid-report at byte 10.
      frame_req = 1'b1;
      @(posedge clk); #1;
      frame_req = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_i("valid_before_reset", int'(tx_valid), 1);
      #2 rst = 1'b1;
      #1;
      check_i("async_reset_clears", int'({tx_data, tx_valid, tx_last, busy}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_i("no_resume_after_reset", int'({tx_valid, busy}), 0);
      end
      send_report(0, 0, -1, got);
      check_w("report_after_reset", got, def_img);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
